// File: rtl/crc_multi_step_stream.sv
// ============================================================================
// Module      : crc_multi_step_stream
// Description : Streaming multi-step CRC engine with valid/ready flow control.
//               Full words fold in one cycle; a partial last word folds one
//               byte per cycle. Optional result checker: CRC_STREAM_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc_multi_step_stream #(
    parameter int              DIN_WIDTH   = 32,
    parameter int              WIDTH       = 32,
    parameter logic [WIDTH-1:0] POLY       = 32'h04C1_1DB7,
    parameter logic [WIDTH-1:0] XOR_IN     = 32'hFFFF_FFFF,
    parameter bit              REFLECT_IN  = 1'b1,
    parameter bit              REFLECT_OUT = 1'b1,
    parameter logic [WIDTH-1:0] XOR_OUT    = 32'hFFFF_FFFF
`ifdef CRC_STREAM_CHECK_EN
    ,
    parameter logic [WIDTH-1:0] CHECK_VALUE = 32'h2144_DF1C
`endif
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DIN_WIDTH-1:0]              din,
    input  logic                              din_valid,
    output logic                              din_ready,
    input  logic                              din_first,
    input  logic                              din_last,
    input  logic [$clog2(DIN_WIDTH/8):0]      din_nbytes,
    output logic [WIDTH-1:0]                  crc_out,
`ifdef CRC_STREAM_CHECK_EN
    output logic                              crc_ok,
`endif
    output logic                              crc_out_valid
);

    localparam int NB  = DIN_WIDTH / 8;
    localparam int NBW = $clog2(NB) + 1;

    localparam logic [NBW-1:0] c_nb  = NB[NBW-1:0];
    localparam logic [NBW-1:0] c_one = {{(NBW-1){1'b0}}, 1'b1};

    localparam logic [1:0] c_st_accept = 2'd0;
    localparam logic [1:0] c_st_tail   = 2'd1;
    localparam logic [1:0] c_st_out    = 2'd2;

    logic [1:0]           r_state;
    logic [WIDTH-1:0]     r_crc;
    logic [DIN_WIDTH-1:0] r_word;
    logic [NBW-1:0]       r_cnt;
    logic [WIDTH-1:0]     r_crc_out;
    logic                 r_out_valid;
`ifdef CRC_STREAM_CHECK_EN
    logic                 r_crc_ok;
`endif

    logic [WIDTH-1:0]     w_seed;
    logic [WIDTH-1:0]     w_word_crc;
    logic [WIDTH-1:0]     w_tail_crc;
    logic                 w_accept;
    logic                 w_partial;

    // MSB-first shift over one byte; reflected input is realised by
    // reversing the byte before it enters the register.
    function automatic logic [WIDTH-1:0] f_fold_byte(input logic [WIDTH-1:0] c_in,
                                                     input logic [7:0] d);
        logic [WIDTH-1:0] c;
        logic [7:0]       b;
        logic             fb;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            b[i] = REFLECT_IN ? d[7-i] : d[i];
        end
        for (int i = 7; i >= 0; i--) begin
            fb = c[WIDTH-1] ^ b[i];
            c  = {c[WIDTH-2:0], 1'b0};
            if (fb) begin
                c = c ^ POLY;
            end
        end
        return c;
    endfunction

    function automatic logic [WIDTH-1:0] f_fold_word(input logic [WIDTH-1:0] c_in,
                                                     input logic [DIN_WIDTH-1:0] w);
        logic [WIDTH-1:0] c;
        c = c_in;
        for (int i = 0; i < NB; i++) begin
            c = f_fold_byte(c, w[DIN_WIDTH-1-8*i -: 8]);
        end
        return c;
    endfunction

    function automatic logic [WIDTH-1:0] f_finish(input logic [WIDTH-1:0] c);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = REFLECT_OUT ? c[WIDTH-1-i] : c[i];
        end
        return r ^ XOR_OUT;
    endfunction

    always_comb begin
        w_accept   = din_valid && din_ready;
        w_seed     = din_first ? XOR_IN : r_crc;
        w_word_crc = f_fold_word(w_seed, din);
        w_tail_crc = f_fold_byte(r_crc, r_word[DIN_WIDTH-1 -: 8]);
        w_partial  = (din_nbytes != '0) && (din_nbytes < c_nb);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_accept;
            r_crc       <= XOR_IN;
            r_word      <= '0;
            r_cnt       <= '0;
            r_crc_out   <= '0;
            r_out_valid <= 1'b0;
`ifdef CRC_STREAM_CHECK_EN
            r_crc_ok    <= 1'b0;
`endif
        end else begin
            r_out_valid <= 1'b0;
`ifdef CRC_STREAM_CHECK_EN
            r_crc_ok    <= 1'b0;
`endif
            case (r_state)
                c_st_accept: begin
                    if (w_accept) begin
                        if (!din_last) begin
                            r_crc <= w_word_crc;
                        end else if (w_partial) begin
                            // Park the seed; the tail bytes are folded serially.
                            r_crc   <= w_seed;
                            r_word  <= din;
                            r_cnt   <= din_nbytes;
                            r_state <= c_st_tail;
                        end else begin
                            r_crc       <= w_word_crc;
                            r_crc_out   <= f_finish(w_word_crc);
                            r_out_valid <= 1'b1;
`ifdef CRC_STREAM_CHECK_EN
                            r_crc_ok    <= (f_finish(w_word_crc) == CHECK_VALUE);
`endif
                            r_state     <= c_st_out;
                        end
                    end
                end
                c_st_tail: begin
                    r_crc  <= w_tail_crc;
                    r_word <= r_word << 8;
                    r_cnt  <= r_cnt - c_one;
                    if (r_cnt == c_one) begin
                        r_crc_out   <= f_finish(w_tail_crc);
                        r_out_valid <= 1'b1;
`ifdef CRC_STREAM_CHECK_EN
                        r_crc_ok    <= (f_finish(w_tail_crc) == CHECK_VALUE);
`endif
                        r_state     <= c_st_out;
                    end
                end
                c_st_out: begin
                    r_crc   <= XOR_IN;
                    r_state <= c_st_accept;
                end
                default: begin
                    r_crc   <= XOR_IN;
                    r_state <= c_st_accept;
                end
            endcase
        end
    end

    assign din_ready     = (r_state == c_st_accept) && !rst;
    assign crc_out       = r_crc_out;
    assign crc_out_valid = r_out_valid;
`ifdef CRC_STREAM_CHECK_EN
    assign crc_ok        = r_crc_ok;
`endif

endmodule

`default_nettype wire

// File: doc/crc_multi_step_stream.md
# crc_multi_step_stream

Streaming, parametrised multi-step CRC engine with valid/ready flow control and a byte-granular final word. Full words are folded one per cycle. A partial last word is folded byte-serially while input is back-pressured. One result is emitted per frame. It sits between a framed byte-stream source (MAC/packetiser, MSB-first word packing) and frame-build or frame-check logic.

## Interface
- DIN_WIDTH, 32, data word width; multiple of 8; NB = DIN_WIDTH/8 bytes per word
- WIDTH, 32, CRC width, 8..64
- POLY, 32'h04C1_1DB7, generator polynomial, normal form, implicit top bit
- XOR_IN, 32'hFFFF_FFFF, register initial value loaded at frame start
- REFLECT_IN, 1, 1 = each input byte bit-reversed before folding
- REFLECT_OUT, 1, 1 = final register bit-reversed over WIDTH before XOR_OUT
- XOR_OUT, 32'hFFFF_FFFF, value XORed onto the reflected register to form crc_out
- CHECK_VALUE, 32'h2144_DF1C, expected crc_out over data plus appended CRC (used only with CRC_STREAM_CHECK_EN)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- din  in  DIN_WIDTH  data word; byte 0 = din[DIN_WIDTH-1 -: 8], processed first
- din_valid  in  1  din/din_first/din_last/din_nbytes valid
- din_ready  out  1  engine accepts a beat this cycle
- din_first  in  1  beat is the first word of a frame
- din_last  in  1  beat is the last word of a frame
- din_nbytes  in  $clog2(NB)+1  valid bytes in last word, most significant first; sampled only with din_last
- crc_out  out  WIDTH  final CRC, stable while crc_out_valid
- crc_out_valid  out  1  one-cycle result strobe
- crc_ok  out  1  crc_out == CHECK_VALUE, qualified by crc_out_valid (only with CRC_STREAM_CHECK_EN)

## Operation
- Beat accepted when din_valid && din_ready.
- FSM states: ACCEPT, TAIL, OUT. Reset state is ACCEPT.
- ACCEPT: din_ready = 1.
  - Accepted beat folds all NB bytes into the seed. Seed is XOR_IN if din_first, else crc_reg.
  - !din_last: stay in ACCEPT, crc_reg updated.
  - din_last with din_nbytes == NB, 0, or > NB: whole word folded. Go to OUT.
  - din_last with 1 <= din_nbytes < NB: latch word and count k = din_nbytes. Load crc_reg with the seed; nothing is folded yet. Go to TAIL.
- TAIL: din_ready = 0. Fold one byte per cycle, most significant remaining byte first. Decrement count. After the k-th byte, go to OUT.
- OUT: din_ready = 0. crc_out_valid = 1 and crc_out = (REFLECT_OUT ? rev(crc_reg) : crc_reg) ^ XOR_OUT. crc_reg reloads XOR_IN. Next state is ACCEPT.
- din_first mid-frame: the open frame is discarded silently and the new frame starts.
- din_first && din_last on the same beat: a single-word frame.
- A frame with no leading din_first is seeded from crc_reg, which is XOR_IN after reset or after OUT.
- Parameters narrower than 64 bits use only their low WIDTH bits. Folding math is modulo POLY over WIDTH bits.

## Timing
- Reset values: din_ready = 0 while rst is high, then 1 after release (ACCEPT). crc_out = 0, crc_out_valid = 0, crc_ok = 0, crc_reg = XOR_IN.
- crc_out holds its last value after the strobe until the next OUT.
- Latency from the last beat accepted at edge t:
  - full word: crc_out_valid high in cycle t+1
  - k-byte partial word: k TAIL cycles, then crc_out_valid high in cycle t+k+1
- Throughput: an n-word frame occupies n+1 cycles (full last word) or n+k+1 cycles (k-byte last word). Back-to-back frames are allowed.
- An upstream beat held with din_valid during TAIL or OUT is accepted on the first cycle back in ACCEPT.
- rst mid-frame, in TAIL, or in OUT: immediately returns to ACCEPT. The pending result is dropped and crc_out_valid is 0.

## Configuration
- CRC_STREAM_CHECK_EN defined: crc_ok port and comparator are present. crc_ok = (crc_out == CHECK_VALUE), registered alongside crc_out_valid. Otherwise 0.
- Undefined: the crc_ok port is absent. No comparator logic is built.

## Test plan
- CRC-32 defaults, frame 0x31323334, 0x35363738, 0x39xxxxxx (last, nbytes = 1): crc_out = 0xCBF43926 two cycles after the last accept; din_ready low for exactly 2 cycles.
- Same data as 0x31323334, 0x35363738, 0x39000000 with nbytes = 4 (full word): crc_out = CRC-32 of the 12 bytes, one cycle after accept; no TAIL cycles.
- Check mode (CRC_STREAM_CHECK_EN), frame 0x31323334, 0x35363738, 0x392639F4, 0xCBxxxxxx (nbytes = 1): crc_out = 0x2144DF1C, crc_ok = 1. Flip one data bit: crc_ok = 0.
- Back-to-back with din_valid held constant: single-word frame 0x31323334 (first+last, nbytes = 4) followed immediately by the 9-byte frame. Two strobes with correct values, and the second frame's first beat is taken on the cycle after OUT.
- din_first reasserted after two words of an open frame, followed by the "123456789" frame: only 0xCBF43926 is output.
- rst pulsed during TAIL of a 3-byte last word: no crc_out_valid; din_ready is 1 on the first cycle after release; the next frame's result is correct.
